// File: rtl/matrix_row_streamer.sv
// Streams every row of a source matrix to a ready/valid consumer. A credit count
// bounds outstanding reads so the small receive FIFO can never overflow.
module matrix_row_streamer #(
    parameter int NUM_ROWS       = 3,
    parameter int NUM_COLS       = 5,
    parameter int SCALAR_BITS    = 32,
    parameter int MEMORY_LATENCY = 2,
    // A one-row matrix still needs a one-bit address port.
    localparam int ROW_ADDR_WIDTH = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int ROW_SIZE       = NUM_COLS * SCALAR_BITS,
    localparam int FIFO_DEPTH     = MEMORY_LATENCY + 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [ROW_ADDR_WIDTH-1:0] row_addr,
    output logic                      row_addr_ready,
    input  logic                      row_valid,
    input  logic [ROW_SIZE-1:0]       row_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ROW_SIZE-1:0]       out_row,
    output logic [ROW_ADDR_WIDTH-1:0] out_row_idx,
    output logic                      out_last
);

    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW    = ROW_ADDR_WIDTH'(NUM_ROWS - 1);
    localparam logic [CNT_WIDTH:0]        DEPTH_LIMIT = (CNT_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH-1:0]      LAST_SLOT   = PTR_WIDTH'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t                    r_state;
    state_t                    w_nextState;
    logic [ROW_ADDR_WIDTH-1:0] r_issueCnt;
    logic [ROW_ADDR_WIDTH-1:0] r_recvCnt;
    logic [CNT_WIDTH-1:0]      r_inFlight;
    logic [CNT_WIDTH-1:0]      r_fifoCount;
    logic [PTR_WIDTH-1:0]      r_wrPtr;
    logic [PTR_WIDTH-1:0]      r_rdPtr;
    logic [ROW_SIZE-1:0]       r_rowMem [FIFO_DEPTH];
    logic [ROW_ADDR_WIDTH-1:0] r_idxMem [FIFO_DEPTH];
    logic                      r_done;

    logic                      w_startAccept;
    logic                      w_issue;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_hasCredit;
    logic                      w_outValid;
    logic                      w_headLast;
    logic                      w_lastHandshake;
    logic [CNT_WIDTH:0]        w_occupancy;

    function automatic logic [PTR_WIDTH-1:0] nextPtr(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    // Rows already requested plus rows waiting in the FIFO must fit in the FIFO.
    assign w_occupancy     = {1'b0, r_fifoCount} + {1'b0, r_inFlight};
    assign w_hasCredit     = w_occupancy < DEPTH_LIMIT;
    assign w_startAccept   = (r_state == IDLE) && start;
    assign w_push          = row_valid && (r_inFlight != '0);
    assign w_outValid      = r_fifoCount != '0;
    assign w_pop           = w_outValid && out_ready;
    assign w_headLast      = w_outValid && (r_idxMem[r_rdPtr] == LAST_ROW);
    assign w_lastHandshake = (r_state == DRAIN) && w_pop && w_headLast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = ISSUE;
                end
            end
            ISSUE: begin
                w_issue = w_hasCredit;
                if (w_hasCredit && (r_issueCnt == LAST_ROW)) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (w_lastHandshake) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The issue counter parks on the last row so row_addr holds once issuing stops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issueCnt <= '0;
            r_recvCnt  <= '0;
        end else if (w_startAccept) begin
            r_issueCnt <= '0;
            r_recvCnt  <= '0;
        end else begin
            if (w_issue && (r_issueCnt != LAST_ROW)) begin
                r_issueCnt <= r_issueCnt + 1'b1;
            end
            if (w_push) begin
                r_recvCnt <= r_recvCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inFlight <= '0;
        end else begin
            case ({w_issue, w_push})
                2'b10:   r_inFlight <= r_inFlight + 1'b1;
                2'b01:   r_inFlight <= r_inFlight - 1'b1;
                default: r_inFlight <= r_inFlight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifoCount <= '0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifoCount <= r_fifoCount + 1'b1;
                2'b01:   r_fifoCount <= r_fifoCount - 1'b1;
                default: r_fifoCount <= r_fifoCount;
            endcase
        end
    end

    // Storage needs no reset; outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rowMem[r_wrPtr] <= row_out;
            r_idxMem[r_wrPtr] <= r_recvCnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_lastHandshake;
        end
    end

    assign busy           = r_state != IDLE;
    assign done           = r_done;
    assign row_addr       = r_issueCnt;
    assign row_addr_ready = w_issue;
    assign out_valid      = w_outValid;
    assign out_row        = w_outValid ? r_rowMem[r_rdPtr] : '0;
    assign out_row_idx    = w_outValid ? r_idxMem[r_rdPtr] : '0;
    assign out_last       = w_headLast;

endmodule

// File: tb/tb_matrix_row_streamer.sv
// Self-checking bench: two streamer instances (4-row and 1-row matrices) driven by
// latency-accurate matrix models and checked against an in-order row scoreboard.
module tb_matrix_row_streamer;

    localparam int NR    = 4;
    localparam int NC    = 4;
    localparam int SB    = 8;
    localparam int ML    = 2;
    localparam int MLB   = 1;
    localparam int RS    = NC * SB;
    localparam int DEPTH = ML + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount  = 0;
    int errorCount  = 0;

    logic          rstA, startA, outReadyA;
    logic          busyA, doneA, rowAddrReadyA, rowValidA, outValidA, outLastA;
    logic [1:0]    rowAddrA, outRowIdxA;
    logic [RS-1:0] rowOutA, outRowA;

    logic          rstB, startB, outReadyB;
    logic          busyB, doneB, rowAddrReadyB, rowValidB, outValidB, outLastB;
    logic [0:0]    rowAddrB, outRowIdxB;
    logic [RS-1:0] rowOutB, outRowB;

    matrix_row_streamer #(
        .NUM_ROWS(NR), .NUM_COLS(NC), .SCALAR_BITS(SB), .MEMORY_LATENCY(ML)
    ) dutA (
        .clk(clk), .rst(rstA), .start(startA), .busy(busyA), .done(doneA),
        .row_addr(rowAddrA), .row_addr_ready(rowAddrReadyA),
        .row_valid(rowValidA), .row_out(rowOutA),
        .out_valid(outValidA), .out_ready(outReadyA), .out_row(outRowA),
        .out_row_idx(outRowIdxA), .out_last(outLastA)
    );

    matrix_row_streamer #(
        .NUM_ROWS(1), .NUM_COLS(NC), .SCALAR_BITS(SB), .MEMORY_LATENCY(MLB)
    ) dutB (
        .clk(clk), .rst(rstB), .start(startB), .busy(busyB), .done(doneB),
        .row_addr(rowAddrB), .row_addr_ready(rowAddrReadyB),
        .row_valid(rowValidB), .row_out(rowOutB),
        .out_valid(outValidB), .out_ready(outReadyB), .out_row(outRowB),
        .out_row_idx(outRowIdxB), .out_last(outLastB)
    );

    // Matrix contents: row r, column c holds r*16+c.
    function automatic logic [RS-1:0] rowData(input int r);
        logic [RS-1:0] d;
        for (int c = 0; c < NC; c++) begin
            d[c*SB +: SB] = SB'(r * 16 + c);
        end
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Matrix models: a request seen in cycle k returns data in cycle k+latency.
    logic       pipeVA    [0:ML]  = '{default: 1'b0};
    logic [1:0] pipeAddrA [0:ML]  = '{default: 2'd0};
    logic       pipeVB    [0:MLB] = '{default: 1'b0};

    always @(negedge clk) begin
        for (int i = ML; i > 0; i--) begin
            pipeVA[i]    = pipeVA[i-1];
            pipeAddrA[i] = pipeAddrA[i-1];
        end
        pipeVA[0]    = rowAddrReadyA;
        pipeAddrA[0] = rowAddrA;
        for (int j = MLB; j > 0; j--) begin
            pipeVB[j] = pipeVB[j-1];
        end
        pipeVB[0] = rowAddrReadyB;
    end

    assign rowValidA = pipeVA[ML];
    assign rowOutA   = rowData(int'(pipeAddrA[ML]));
    assign rowValidB = pipeVB[MLB];
    assign rowOutB   = rowData(0);

    // Scoreboard for dutA: rows must leave in order 0..NR-1 with the matrix contents.
    int            expIdxA      = 0;
    int            outstandingA = 0;
    int            strobeCntA   = 0;
    int            deliverCntA  = 0;
    int            doneCntA     = 0;
    bit            prevStallA   = 1'b0;
    logic [RS-1:0] prevRowA;
    logic [1:0]    prevIdxA;

    always @(negedge clk) begin
        if (rstA) begin
            expIdxA      = 0;
            outstandingA = 0;
            prevStallA   = 1'b0;
        end else begin
            if (prevStallA) begin
                checkOutput("stallValid", 64'(outValidA), 64'd1);
                checkOutput("stallRow", 64'(outRowA), 64'(prevRowA));
                checkOutput("stallIdx", 64'(outRowIdxA), 64'(prevIdxA));
            end
            if (rowAddrReadyA) begin
                strobeCntA++;
                outstandingA++;
                checkOutput("occupancyLimit", 64'(outstandingA <= DEPTH), 64'd1);
            end
            if (outValidA && outReadyA) begin
                deliverCntA++;
                outstandingA--;
                checkOutput("rowIdx", 64'(outRowIdxA), 64'(expIdxA));
                checkOutput("rowData", 64'(outRowA), 64'(rowData(expIdxA)));
                checkOutput("rowLast", 64'(outLastA), 64'(expIdxA == NR - 1));
                expIdxA = (expIdxA + 1) % NR;
            end
            if (doneA) begin
                doneCntA++;
            end
            prevStallA = outValidA && !outReadyA;
            prevRowA   = outRowA;
            prevIdxA   = outRowIdxA;
        end
    end

    task automatic applyStimulus(input logic s, input logic rdy, input bit toB = 1'b0);
        @(posedge clk);
        #1;
        if (toB) begin
            startB    = s;
            outReadyB = rdy;
        end else begin
            startA    = s;
            outReadyA = rdy;
        end
    endtask

    task automatic clearCounters();
        strobeCntA  = 0;
        deliverCntA = 0;
        doneCntA    = 0;
    endtask

    task automatic runPass(input int budget, input bit randomReady);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            applyStimulus(1'b0, randomReady ? 1'($urandom_range(0, 1)) : 1'b1);
            if (doneA) seen = 1'b1;
        end
        checkOutput("passDone", 64'(seen), 64'd1);
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, "Busy"}, 64'(busyA), 64'd0);
        checkOutput({tag, "Done"}, 64'(doneA), 64'd0);
        checkOutput({tag, "AddrReady"}, 64'(rowAddrReadyA), 64'd0);
        checkOutput({tag, "OutValid"}, 64'(outValidA), 64'd0);
        checkOutput({tag, "RowAddr"}, 64'(rowAddrA), 64'd0);
        checkOutput({tag, "OutIdx"}, 64'(outRowIdxA), 64'd0);
        checkOutput({tag, "OutLast"}, 64'(outLastA), 64'd0);
        checkOutput({tag, "OutRow"}, 64'(outRowA), 64'd0);
    endtask

    initial begin
        rstA = 1'b1; startA = 1'b0; outReadyA = 1'b0;
        rstB = 1'b1; startB = 1'b0; outReadyB = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetA("reset");
        checkOutput("resetBusyB", 64'(busyB), 64'd0);
        checkOutput("resetValidB", 64'(outValidB), 64'd0);
        rstA = 1'b0;
        rstB = 1'b0;

        // Full-throughput pass: issue cycles 1-4, deliver 4-7, done in 8.
        clearCounters();
        applyStimulus(1'b1, 1'b1);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("t1AddrReady", 64'(rowAddrReadyA), 64'(cyc >= 1 && cyc <= 4));
            if (cyc >= 1 && cyc <= 4) checkOutput("t1RowAddr", 64'(rowAddrA), 64'(cyc - 1));
            checkOutput("t1OutValid", 64'(outValidA), 64'(cyc >= 4 && cyc <= 7));
            if (cyc >= 4 && cyc <= 7) checkOutput("t1OutIdx", 64'(outRowIdxA), 64'(cyc - 4));
            checkOutput("t1OutLast", 64'(outLastA), 64'(cyc == 7));
            checkOutput("t1Done", 64'(doneA), 64'(cyc == 8));
            checkOutput("t1Busy", 64'(busyA), 64'(cyc >= 1 && cyc <= 7));
        end
        checkOutput("t1DoneCount", 64'(doneCntA), 64'd1);
        checkOutput("t1Delivered", 64'(deliverCntA), 64'(NR));

        // Back-pressure: only DEPTH reads may be outstanding, then drain intact.
        clearCounters();
        applyStimulus(1'b1, 1'b0);
        repeat (12) applyStimulus(1'b0, 1'b0);
        checkOutput("t2Issued", 64'(strobeCntA), 64'(DEPTH));
        checkOutput("t2AddrReady", 64'(rowAddrReadyA), 64'd0);
        checkOutput("t2HeadValid", 64'(outValidA), 64'd1);
        checkOutput("t2HeadIdx", 64'(outRowIdxA), 64'd0);
        runPass(30, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t2Delivered", 64'(deliverCntA), 64'(NR));

        // Random back-pressure over several passes.
        for (int p = 0; p < 4; p++) begin
            clearCounters();
            applyStimulus(1'b1, 1'($urandom_range(0, 1)));
            runPass(300, 1'b1);
            applyStimulus(1'b0, 1'b1);
            applyStimulus(1'b0, 1'b1);
            checkOutput("t3Delivered", 64'(deliverCntA), 64'(NR));
            checkOutput("t3DoneCount", 64'(doneCntA), 64'd1);
            checkOutput("t3Issued", 64'(strobeCntA), 64'(NR));
        end

        // Starts during a pass are ignored; a start in the done cycle is taken.
        clearCounters();
        applyStimulus(1'b1, 1'b1);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            applyStimulus(1'(cyc == 2 || cyc == 5 || cyc == 8), 1'b1);
        end
        checkOutput("t4DoneCycle", 64'(doneA), 64'd1);
        checkOutput("t4FirstIssued", 64'(strobeCntA), 64'(NR));
        applyStimulus(1'b0, 1'b1);
        checkOutput("t4RestartReady", 64'(rowAddrReadyA), 64'd1);
        checkOutput("t4RestartAddr", 64'(rowAddrA), 64'd0);
        checkOutput("t4RestartBusy", 64'(busyA), 64'd1);
        runPass(30, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t4DoneCount", 64'(doneCntA), 64'd2);
        checkOutput("t4Delivered", 64'(deliverCntA), 64'(2 * NR));

        // Reset in cycle 3 abandons the pass; late returns must be dropped.
        clearCounters();
        applyStimulus(1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b1);
        rstA = 1'b1;
        #1;
        checkResetA("midReset");
        applyStimulus(1'b0, 1'b1);
        rstA = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("t5NoValid", 64'(outValidA), 64'd0);
            checkOutput("t5NoIssue", 64'(rowAddrReadyA), 64'd0);
            checkOutput("t5Idle", 64'(busyA), 64'd0);
        end
        clearCounters();
        applyStimulus(1'b1, 1'b1);
        runPass(30, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t5Delivered", 64'(deliverCntA), 64'(NR));
        checkOutput("t5DoneCount", 64'(doneCntA), 64'd1);

        // Single-row matrix with one-cycle memory.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("t6AddrReady", 64'(rowAddrReadyB), 64'(cyc == 1));
            checkOutput("t6RowAddr", 64'(rowAddrB), 64'd0);
            checkOutput("t6OutValid", 64'(outValidB), 64'(cyc == 3));
            checkOutput("t6OutLast", 64'(outLastB), 64'(cyc == 3));
            if (cyc == 3) begin
                checkOutput("t6OutIdx", 64'(outRowIdxB), 64'd0);
                checkOutput("t6OutRow", 64'(outRowB), 64'(rowData(0)));
            end
            checkOutput("t6Done", 64'(doneB), 64'(cyc == 4));
            checkOutput("t6Busy", 64'(busyB), 64'(cyc >= 1 && cyc <= 3));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
